// File: rtl/fifo_rv_1r1w.sv
// Valid/ready FIFO with first-word-fall-through read, occupancy count,
// almost-full/almost-empty flags and synchronous flush; any DEPTH >= 2.
module fifo_rv_1r1w #(
  parameter int DWIDTH        = 8,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_wvalid,
  output logic                       o_wready,
  input  logic [DWIDTH-1:0]          i_wdata,
  output logic                       o_rvalid,
  input  logic                       i_rready,
  output logic [DWIDTH-1:0]          o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full,
  output logic                       o_almost_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_idx_r;
  logic [AW-1:0]     rd_idx_r;
  logic [CW-1:0]     count_r;
  logic [AW-1:0]     wr_idx_nxt_s;
  logic [AW-1:0]     rd_idx_nxt_s;
  logic              push_s;
  logic              pop_s;

  // Flags decode from the count register only, so handshakes never loop back.
  assign o_wready       = (count_r != CW'(DEPTH));
  assign o_rvalid       = (count_r != {CW{1'b0}});
  assign o_almost_full  = (count_r >= CW'(AFULL_THRESH));
  assign o_almost_empty = (count_r <= CW'(AEMPTY_THRESH));
  assign o_count        = count_r;
  assign o_rdata        = mem_r[rd_idx_r];

  assign push_s = i_wvalid & o_wready;
  assign pop_s  = i_rready & o_rvalid;

  // Explicit wrap keeps non-power-of-2 depths correct.
  assign wr_idx_nxt_s = (wr_idx_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : wr_idx_r + AW'(1);
  assign rd_idx_nxt_s = (rd_idx_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : rd_idx_r + AW'(1);

  // Storage array, intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_idx_r] <= i_wdata;
    end
  end

  // Index and occupancy state with reset > flush > push/pop priority.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_idx_r <= {AW{1'b0}};
      rd_idx_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_idx_r <= wr_idx_nxt_s;
      end
      if (pop_s) begin
        rd_idx_r <= rd_idx_nxt_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef SIMULATION
  fifo_rv_1r1w_chk #(
    .DWIDTH       (DWIDTH),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL_THRESH),
    .AEMPTY_THRESH(AEMPTY_THRESH),
    .AW           (AW),
    .CW           (CW)
  ) u_chk (
    .clk   (i_clk),
    .rst   (i_rst),
    .wvalid(i_wvalid),
    .wready(o_wready),
    .wdata (i_wdata),
    .wr_idx(wr_idx_r),
    .rd_idx(rd_idx_r),
    .count (count_r)
  );
`endif

endmodule

`ifdef SIMULATION
// Invariant checker: parameter ranges, index/count consistency, held-off data stability.
module fifo_rv_1r1w_chk #(
  parameter int DWIDTH        = 8,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = 3,
  parameter int AEMPTY_THRESH = 1,
  parameter int AW            = 2,
  parameter int CW            = 3
) (
  input logic              clk,
  input logic              rst,
  input logic              wvalid,
  input logic              wready,
  input logic [DWIDTH-1:0] wdata,
  input logic [AW-1:0]     wr_idx,
  input logic [AW-1:0]     rd_idx,
  input logic [CW-1:0]     count
);

  if (DWIDTH < 1) $error("DWIDTH must be >= 1");
  if (DEPTH < 2) $error("DEPTH must be >= 2");
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) $error("AFULL_THRESH out of range");
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) $error("AEMPTY_THRESH out of range");

  int diff_s;
  assign diff_s = (int'(wr_idx) >= int'(rd_idx)) ? int'(wr_idx) - int'(rd_idx)
                                                 : int'(wr_idx) + DEPTH - int'(rd_idx);

  a_count_range: assert property (@(posedge clk) disable iff (rst) int'(count) <= DEPTH);
  a_idx_range:   assert property (@(posedge clk) disable iff (rst)
                                  int'(wr_idx) < DEPTH && int'(rd_idx) < DEPTH);
  a_count_diff:  assert property (@(posedge clk) disable iff (rst)
                                  (diff_s == 0) ? (count == '0 || int'(count) == DEPTH)
                                                : (int'(count) == diff_s));
  a_wdata_hold:  assert property (@(posedge clk) disable iff (rst)
                                  (wvalid && !wready) |=> (!wvalid || $stable(wdata)));

endmodule
`endif

// File: tb/tb_fifo_rv_1r1w.sv
// Directed bench: DEPTH=3 instance for fill/wrap/streaming, DEPTH=4 for flags, flush, reset.
module tb_fifo_rv_1r1w;

  logic       clk;
  logic       rst3, rst4;
  logic       flush;
  logic       wvalid, rready;
  logic [7:0] wdata;

  logic       wready3, rvalid3, af3, ae3;
  logic [7:0] rdata3;
  logic [1:0] count3;
  logic       wready4, rvalid4, af4, ae4;
  logic [7:0] rdata4;
  logic [2:0] count4;

  int n_checks = 0;
  int n_errors = 0;

  fifo_rv_1r1w #(.DWIDTH(8), .DEPTH(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_flush(flush),
    .i_wvalid(wvalid), .o_wready(wready3), .i_wdata(wdata),
    .o_rvalid(rvalid3), .i_rready(rready), .o_rdata(rdata3),
    .o_count(count3), .o_almost_full(af3), .o_almost_empty(ae3)
  );

  fifo_rv_1r1w #(.DWIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_dut4 (
    .i_clk(clk), .i_rst(rst4), .i_flush(flush),
    .i_wvalid(wvalid), .o_wready(wready4), .i_wdata(wdata),
    .o_rvalid(rvalid4), .i_rready(rready), .o_rdata(rdata4),
    .o_count(count4), .o_almost_full(af4), .o_almost_empty(ae4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic ae_tbl [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic af_tbl [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst3 = 1'b1; rst4 = 1'b1; flush = 1'b0;
    wvalid = 1'b0; rready = 1'b0; wdata = 8'h00;
    step(); step();
    rst3 = 1'b0;
    chk("rst3_count",  count3,  32'd0);
    chk("rst3_rvalid", rvalid3, 32'd0);
    chk("rst3_wready", wready3, 32'd1);
    chk("rst3_ae",     ae3,     32'd1);
    chk("rst3_af",     af3,     32'd0);

    // Fill DEPTH=3 with no reads.
    wvalid = 1'b1; wdata = 8'hA1; step();
    chk("fill_cnt1", count3, 32'd1);
    chk("fill_rv1",  rvalid3, 32'd1);
    chk("fill_rd1",  rdata3, 32'hA1);
    wdata = 8'hA2; step();
    chk("fill_cnt2", count3, 32'd2);
    chk("fill_rd2",  rdata3, 32'hA1);
    wdata = 8'hA3; step();
    chk("fill_cnt3", count3, 32'd3);
    chk("fill_wr3",  wready3, 32'd0);
    chk("fill_rd3",  rdata3, 32'hA1);
    chk("fill_af3",  af3, 32'd1);

    // Full with write held off and read active.
    wdata = 8'hA4; rready = 1'b1; step();
    chk("full_cnt_a", count3, 32'd2);
    chk("full_rd_a",  rdata3, 32'hA2);
    chk("full_wr_a",  wready3, 32'd1);
    step();
    chk("full_cnt_b", count3, 32'd2);
    chk("full_rd_b",  rdata3, 32'hA3);
    wvalid = 1'b0; step();
    chk("full_cnt_c", count3, 32'd1);
    chk("full_rd_c",  rdata3, 32'hA4);
    step();
    chk("full_cnt_d", count3, 32'd0);
    chk("full_rv_d",  rvalid3, 32'd0);

    // Streaming at count=1.
    rready = 1'b0; wvalid = 1'b1; wdata = 8'h10; step();
    chk("strm_prime", count3, 32'd1);
    rready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      wdata = 8'h10 + 8'(i);
      chk("strm_rd", rdata3, 32'h10 + 32'(i) - 32'd1);
      chk("strm_rv", rvalid3, 32'd1);
      step();
      chk("strm_cnt", count3, 32'd1);
    end
    wvalid = 1'b0; step();
    chk("strm_drain", count3, 32'd0);

    // Switch to DEPTH=4 instance; flag thresholds across every count.
    rready = 1'b0; rst3 = 1'b1; rst4 = 1'b1; step();
    rst4 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      chk("thr_cnt", count4, 32'(k));
      chk("thr_ae",  ae4, 32'(ae_tbl[k]));
      chk("thr_af",  af4, 32'(af_tbl[k]));
      wvalid = (k < 4); wdata = 8'hB0 + 8'(k);
      step();
    end
    chk("thr_wready_full", wready4, 32'd0);

    // Drain to 2, then flush with push and pop asserted.
    wvalid = 1'b0; rready = 1'b1; step(); step();
    chk("fl_pre_cnt", count4, 32'd2);
    chk("fl_pre_rd",  rdata4, 32'hB2);
    flush = 1'b1; wvalid = 1'b1; wdata = 8'hEE; step();
    flush = 1'b0; wvalid = 1'b0; rready = 1'b0;
    chk("fl_cnt",    count4,  32'd0);
    chk("fl_rvalid", rvalid4, 32'd0);
    chk("fl_wready", wready4, 32'd1);
    chk("fl_ae",     ae4,     32'd1);
    chk("fl_af",     af4,     32'd0);
    step();
    chk("fl_hold_cnt", count4, 32'd0);
    wvalid = 1'b1; wdata = 8'h33; step();
    chk("fl_post_rd",  rdata4, 32'h33);
    chk("fl_post_cnt", count4, 32'd1);

    // Reset mid-stream at count=3.
    wdata = 8'h34; step();
    wdata = 8'h35; step();
    chk("rs_pre_cnt", count4, 32'd3);
    rst4 = 1'b1; wdata = 8'h36; rready = 1'b1; step();
    rst4 = 1'b0; wvalid = 1'b0; rready = 1'b0;
    chk("rs_cnt",    count4,  32'd0);
    chk("rs_rvalid", rvalid4, 32'd0);
    chk("rs_wready", wready4, 32'd1);
    chk("rs_ae",     ae4,     32'd1);
    chk("rs_af",     af4,     32'd0);
    wvalid = 1'b1; wdata = 8'h5C; step();
    wvalid = 1'b0;
    chk("rs_post_rd",  rdata4, 32'h5C);
    chk("rs_post_cnt", count4, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
